// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: opcodes, fetch FSM states, error codes and
// the branch-offset helper used by the next-PC logic.
package cpu_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_ILLEGAL = 2'd2
  } err_e;

  // Word-aligned, sign-extended byte offset of a 16-bit branch immediate.
  function automatic logic [31:0] branch_offset(logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: jump target, taken branch target, or the
// sequential pc+4. All arithmetic wraps modulo 2^32.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] target_field,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;

  assign pc_plus4      = pc + 32'd4;
  assign jump_target   = {pc_plus4[31:28], target_field, 2'b00};
  assign branch_target = pc_plus4 + branch_offset(target_field[15:0]);

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch/issue front end: owns the PC, fetches over the imem req/ack
// bus and holds the fetched word valid until the datapath retires it.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  instr_fetch_unit_if.master imem,
  output logic [31:0]        instr,
  output logic [5:0]         op,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump,
  input  logic               branch,
  input  logic               zero,
  input  logic               illegal_op,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               halted,
  output logic [1:0]         err_code
);

  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state, state_nxt;
  err_e             err_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      next_pc;
  logic             timeout_hit;
  logic             retire;

  assign timeout_hit = (wait_cnt == CNT_LAST);
  // Decoder inputs are only looked at here, so X on them elsewhere never reaches pc.
  assign retire      = (state == S_ISSUE) && instr_ready;

  next_pc_calc u_next_pc (
    .pc           (pc),
    .target_field (instr[25:0]),
    .jump         (jump),
    .branch       (branch),
    .zero         (zero),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc)
  );

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem.imem_ack) begin
          state_nxt = S_ISSUE;
        end else if (timeout_hit) begin
          state_nxt = S_HALT;
        end
      end
      S_ISSUE: begin
        if (retire) begin
          state_nxt = illegal_op ? S_HALT : S_FETCH;
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      instr    <= '0;
      wait_cnt <= '0;
      err_q    <= ERR_NONE;
    end else begin
      if (state == S_WAIT) begin
        // An ack on the final wait cycle still counts: ack wins over timeout.
        if (imem.imem_ack) begin
          instr    <= imem.imem_rdata;
          wait_cnt <= '0;
        end else if (timeout_hit) begin
          err_q    <= ERR_TIMEOUT;
        end else begin
          wait_cnt <= wait_cnt + CNT_W'(1);
        end
      end
      if (retire) begin
        if (illegal_op) begin
          err_q <= ERR_ILLEGAL;
        end else begin
          pc    <= next_pc;
        end
      end
    end
  end

  // Request is decoded from state so an async reset drops it immediately.
  assign imem.imem_req  = (state == S_FETCH) || (state == S_WAIT);
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == S_ISSUE);
  assign halted         = (state == S_HALT);
  assign op             = instr[31:26];
  assign err_code       = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory/decoder responder, an instruction-level
// PC model compared every cycle, and directed scenarios with literal checks.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  localparam int          TO  = 16;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump, branch, zero, illegal_op;
  logic [31:0] pc, pc_plus4;
  logic        halted;
  logic [1:0]  err_code;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem        (bus),
    .instr       (instr),
    .op          (op),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .illegal_op  (illegal_op),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .halted      (halted),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus configuration shared by the responder and the scenarios.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] fetch_q [$];
  int          ack_delay    = 1;
  int          retire_limit = 0;
  int          retired      = 0;
  logic        zero_cfg     = 1'b0;
  logic [31:0] illegal_addr = 32'h1;
  int          rsp_age      = 0;
  int          dec_age      = 0;

  // Instruction-level model state.
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_halted;
  logic [1:0]  m_err;
  int          m_age;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] addr);
    return mem.exists(addr) ? mem[addr] : NOP;
  endfunction

  function automatic logic [31:0] q_at(input int i);
    return (i < fetch_q.size()) ? fetch_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic j, input logic b, input logic z);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      off = int'($signed(w[15:0]));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  // Memory and decoder responder, driven just after each rising edge.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    instr_ready    = 1'b0;
    jump = 1'b0; branch = 1'b0; zero = 1'b0; illegal_op = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.imem_req) begin
        if (rsp_age == 0) fetch_q.push_back(bus.imem_addr);
        if (rsp_age >= ack_delay) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_rd(bus.imem_addr);
        end else begin
          bus.imem_ack   = 1'b0;
          bus.imem_rdata = $urandom;
        end
        rsp_age++;
      end else begin
        rsp_age        = 0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
      end
      if (instr_valid) begin
        dec_age++;
        instr_ready = (dec_age >= 2) && (retired < retire_limit);
        jump        = (op == OP_J);
        branch      = (op == OP_BEQ);
        zero        = zero_cfg;
        illegal_op  = (pc == illegal_addr);
      end else begin
        dec_age     = 0;
        instr_ready = 1'b1;
        jump = 1'bx; branch = 1'bx; zero = 1'bx; illegal_op = 1'bx;
      end
    end
  end

  // Per-cycle compare against the model, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_pc = RPC; m_instr = '0; m_valid = 1'b0; m_halted = 1'b0; m_err = 2'd0; m_age = 0;
      end
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("instr", instr, m_instr);
      check("op", 32'(op), 32'(m_instr[31:26]));
      check("instr_valid", 32'(instr_valid), 32'(m_valid));
      check("halted", 32'(halted), 32'(m_halted));
      check("err_code", 32'(err_code), 32'(m_err));
      if (bus.imem_req) check("imem_addr", bus.imem_addr, m_pc);
      if (m_valid || m_halted) check("imem_req_quiet", 32'(bus.imem_req), 32'd0);
      if (reset_n) begin
        if (instr_valid && instr_ready) retired++;
        if (m_valid && instr_ready) begin
          m_valid = 1'b0;
          if (illegal_op === 1'b1) begin
            m_halted = 1'b1;
            m_err    = 2'd2;
          end else begin
            m_pc = model_next(m_pc, m_instr, jump, branch, zero);
          end
        end
        if (bus.imem_req) begin
          if (bus.imem_ack && m_age >= 1) begin
            m_instr = bus.imem_rdata;
            m_valid = 1'b1;
            m_age   = 0;
          end else if (m_age == TO) begin
            m_halted = 1'b1;
            m_err    = 2'd1;
            m_age    = 0;
          end else begin
            m_age++;
          end
        end else begin
          m_age = 0;
        end
      end
    end
  end

  function automatic logic cond(input int what);
    case (what)
      0:       return bus.imem_req;
      1:       return instr_valid;
      default: return halted;
    endcase
  endfunction

  task automatic wait_for(input int what, input int budget, output int cycles);
    cycles = 0;
    while (!cond(what) && cycles < budget) begin
      @(negedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic wait_retired(input int n, input string name);
    int k = 0;
    while (retired < n && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(name, retired, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n      = 1'b0;
    mem.delete();
    fetch_q.delete();
    retired      = 0;
    ack_delay    = 1;
    retire_limit = 0;
    zero_cfg     = 1'b0;
    illegal_addr = 32'h1;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, n, k;
    #1 reset_n = 1'b0;

    // Reset values, then first fetch with a 2-cycle ack.
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_pc", pc, 32'h0000_0000);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_err", 32'(err_code), 32'd0);
    mem[32'h0] = 32'h8C01_0004;
    reset_n = 1'b1;
    wait_for(0, 10, c);
    check("s1_req", 32'(bus.imem_req), 32'd1);
    check("s1_addr", bus.imem_addr, 32'h0000_0000);
    wait_for(1, 10, c);
    check("s1_latency", c, 32'd2);
    check("s1_op", 32'(op), 32'(6'b100011));
    check("s1_instr", instr, 32'h8C01_0004);
    repeat (3) @(negedge clk);
    #1;
    check("s1_valid_held", 32'(instr_valid), 32'd1);
    check("s1_req_low", 32'(bus.imem_req), 32'd0);

    // Three sequential instructions, ack also raised during FETCH (ignored).
    do_reset();
    mem[32'h0] = 32'h8C01_0004;
    mem[32'h4] = 32'hAC01_0008;
    mem[32'h8] = 32'h0000_0020;
    ack_delay = 0;
    retire_limit = 3;
    reset_n = 1'b1;
    wait_retired(3, "s2_retired");
    @(negedge clk);
    #1;
    check("s2_pc", pc, 32'h0000_000C);
    check("s2_addr0", q_at(0), 32'h0);
    check("s2_addr1", q_at(1), 32'h4);
    check("s2_addr2", q_at(2), 32'h8);

    // Jump at 0x10.
    do_reset();
    mem[32'h10] = 32'h0800_0040;
    ack_delay = 2;
    retire_limit = 5;
    reset_n = 1'b1;
    wait_retired(5, "s3_retired");
    @(negedge clk);
    #1;
    check("s3_pc", pc, 32'h0000_0100);
    wait_for(0, 10, c);
    check("s3_addr", bus.imem_addr, 32'h0000_0100);

    // BEQ at 0x20 with imm FFFE, taken then not taken.
    for (int t = 0; t < 2; t++) begin
      do_reset();
      mem[32'h20] = 32'h1000_FFFE;
      zero_cfg = (t == 0);
      retire_limit = 9;
      reset_n = 1'b1;
      wait_retired(9, "s4_retired");
      @(negedge clk);
      #1;
      check(t == 0 ? "s4_beq_taken" : "s4_beq_not_taken", pc,
            t == 0 ? 32'h0000_001C : 32'h0000_0024);
    end

    // Fetch timeout.
    do_reset();
    ack_delay = 1000;
    reset_n = 1'b1;
    wait_for(0, 10, c);
    n = 0;
    k = 0;
    while (!halted && k < 60) begin
      if (bus.imem_req) n++;
      @(negedge clk);
      #1;
      k++;
    end
    check("s5_req_cycles", n, TO + 1);
    check("s5_halted", 32'(halted), 32'd1);
    check("s5_err", 32'(err_code), 32'd1);
    check("s5_req", 32'(bus.imem_req), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("s5_sticky", 32'(halted), 32'd1);

    // Reset asserted in the middle of WAIT.
    do_reset();
    retire_limit = 2;
    reset_n = 1'b1;
    wait_retired(2, "s6_retired");
    ack_delay = 1000;
    wait_for(0, 10, c);
    check("s6_addr", bus.imem_addr, 32'h0000_0008);
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("s6_req_drop", 32'(bus.imem_req), 32'd0);
    check("s6_pc", pc, RPC);

    // Ack on the last WAIT cycle beats the timeout.
    do_reset();
    ack_delay = TO;
    reset_n = 1'b1;
    wait_for(1, 40, c);
    check("s7_valid", 32'(instr_valid), 32'd1);
    check("s7_halted", 32'(halted), 32'd0);
    check("s7_err", 32'(err_code), 32'd0);

    // Illegal opcode at 0x4.
    do_reset();
    illegal_addr = 32'h4;
    retire_limit = 5;
    reset_n = 1'b1;
    wait_for(2, 100, c);
    check("s8_halted", 32'(halted), 32'd1);
    check("s8_err", 32'(err_code), 32'd2);
    check("s8_pc", pc, 32'h0000_0004);

    // Backward branch from 0 to FFFF_FFFC, then wrap to 0.
    do_reset();
    mem[32'h0] = 32'h1000_FFFE;
    zero_cfg = 1'b1;
    retire_limit = 1;
    reset_n = 1'b1;
    wait_retired(1, "s9_retired1");
    @(negedge clk);
    #1;
    check("s9_pc_top", pc, 32'hFFFF_FFFC);
    check("s9_plus4_wrap", pc_plus4, 32'h0000_0000);
    retire_limit = 2;
    wait_retired(2, "s9_retired2");
    @(negedge clk);
    #1;
    check("s9_pc_wrap", pc, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
